// File: rtl/ppd_subfilter_bank.sv
// Polyphase decimator branch-filter stage: per accepted frame, pushes M channel samples into
// M L-deep delay lines and sums all branch FIRs through one time-shared signed MAC.
module ppd_subfilter_bank #(
    parameter int gp_idata_width       = 8,
    parameter int gp_decimation_factor = 4,
    parameter int gp_taps_per_phase    = 4,
    parameter int gp_coeff_width       = 8,
    localparam int c_num_taps   = gp_decimation_factor * gp_taps_per_phase,
    localparam int c_addr_width = (c_num_taps > 1) ? $clog2(c_num_taps) : 1,
    localparam int c_acc_width  = gp_idata_width + gp_coeff_width + $clog2(c_num_taps)
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic                                           i_ena,
    input  logic                                           i_vld,
    input  logic [gp_decimation_factor*gp_idata_width-1:0] i_data,
    input  logic                                           i_coeff_wr,
    input  logic [c_addr_width-1:0]                        i_coeff_addr,
    input  logic [gp_coeff_width-1:0]                      i_coeff_data,
    input  logic                                           i_ovf_clr,
    output logic [c_acc_width-1:0]                         o_data,
    output logic                                           o_vld,
    output logic                                           o_busy,
    output logic                                           o_ovf
);

    localparam int c_b_width = (gp_decimation_factor > 1) ? $clog2(gp_decimation_factor) : 1;
    localparam int c_k_width = (gp_taps_per_phase > 1) ? $clog2(gp_taps_per_phase) : 1;
    localparam logic [c_b_width-1:0] c_b_last = c_b_width'(gp_decimation_factor - 1);
    localparam logic [c_k_width-1:0] c_k_last = c_k_width'(gp_taps_per_phase - 1);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_mac  = 2'd1,
        st_done = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic signed [gp_idata_width-1:0] dline_r [gp_decimation_factor][gp_taps_per_phase];
    logic signed [gp_coeff_width-1:0] coeff_r [c_num_taps];

    logic [c_b_width-1:0]          b_cnt_r;
    logic [c_k_width-1:0]          k_cnt_r;
    logic signed [c_acc_width-1:0] acc_r;
    logic [c_acc_width-1:0]        data_r;
    logic                          vld_r;
    logic                          busy_r;
    logic                          ovf_r;

    logic                          accept_s;
    logic                          drop_s;
    logic                          last_s;
    logic                          coeff_we_s;
    logic [c_addr_width-1:0]       tap_addr_s;
    logic signed [c_acc_width-1:0] coeff_ext_s;
    logic signed [c_acc_width-1:0] sample_ext_s;
    logic signed [c_acc_width-1:0] prod_s;
    logic signed [c_acc_width-1:0] acc_sum_s;

    // Next-state decode; frames arriving outside IDLE are flagged for dropping
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            st_idle: begin
                if (i_vld) begin
                    state_next_s = st_mac;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = st_idle;
                end
            end
            st_mac: begin
                drop_s = i_vld;
                if (last_s) begin
                    state_next_s = st_done;
                end else begin
                    state_next_s = st_mac;
                end
            end
            st_done: begin
                drop_s       = i_vld;
                state_next_s = st_idle;
            end
            default: begin
                state_next_s = st_idle;
            end
        endcase
    end

    // Tap selection and full-precision product, operands sign-extended to the accumulator width
    always_comb begin
        last_s       = (b_cnt_r == c_b_last) && (k_cnt_r == c_k_last);
        tap_addr_s   = c_addr_width'(int'(b_cnt_r) * gp_taps_per_phase + int'(k_cnt_r));
        coeff_ext_s  = c_acc_width'(coeff_r[tap_addr_s]);
        sample_ext_s = c_acc_width'(dline_r[b_cnt_r][k_cnt_r]);
        prod_s       = coeff_ext_s * sample_ext_s;
        acc_sum_s    = acc_r + prod_s;
    end

    // Coefficient writes land only while idle and only for in-range addresses
    always_comb begin
        if (i_ena && i_coeff_wr && (state_r == st_idle)) begin
            coeff_we_s = ({1'b0, i_coeff_addr} < (c_addr_width + 1)'(c_num_taps));
        end else begin
            coeff_we_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= st_idle;
        end else if (i_ena) begin
            state_r <= state_next_s;
        end
    end

    // Per-branch delay lines shift once per accepted frame
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < gp_decimation_factor; b++) begin
                for (int k = 0; k < gp_taps_per_phase; k++) begin
                    dline_r[b][k] <= '0;
                end
            end
        end else if (i_ena && accept_s) begin
            for (int b = 0; b < gp_decimation_factor; b++) begin
                dline_r[b][0] <= i_data[b*gp_idata_width +: gp_idata_width];
                for (int k = 1; k < gp_taps_per_phase; k++) begin
                    dline_r[b][k] <= dline_r[b][k-1];
                end
            end
        end
    end

    // Coefficient RAM, address a = b*L + k
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int a = 0; a < c_num_taps; a++) begin
                coeff_r[a] <= '0;
            end
        end else if (coeff_we_s) begin
            coeff_r[i_coeff_addr] <= i_coeff_data;
        end
    end

    // Accumulator and tap counters: branch b is the outer loop, tap k the inner loop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_r   <= '0;
            b_cnt_r <= '0;
            k_cnt_r <= '0;
        end else if (i_ena) begin
            if (accept_s) begin
                acc_r   <= '0;
                b_cnt_r <= '0;
                k_cnt_r <= '0;
            end else if (state_r == st_mac) begin
                acc_r <= acc_sum_s;
                if (last_s) begin
                    b_cnt_r <= '0;
                    k_cnt_r <= '0;
                end else if (k_cnt_r == c_k_last) begin
                    b_cnt_r <= b_cnt_r + c_b_width'(1);
                    k_cnt_r <= '0;
                end else begin
                    k_cnt_r <= k_cnt_r + c_k_width'(1);
                end
            end
        end
    end

    // Result capture on the final product so o_vld and o_data appear together in DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_r <= '0;
            vld_r  <= 1'b0;
            busy_r <= 1'b0;
        end else if (i_ena) begin
            vld_r  <= (state_r == st_mac) && last_s;
            busy_r <= (state_next_s != st_idle);
            if ((state_r == st_mac) && last_s) begin
                data_r <= acc_sum_s;
            end
        end
    end

    // Sticky drop flag; a new drop outranks a simultaneous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_r <= 1'b0;
        end else if (i_ena) begin
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (i_ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign o_data = data_r;
    assign o_vld  = vld_r;
    assign o_busy = busy_r;
    assign o_ovf  = ovf_r;

endmodule

// File: tb/tb_ppd_subfilter_bank.sv
// Directed and randomized checks of ppd_subfilter_bank against a sum-of-products reference model.
module tb_ppd_subfilter_bank;

    localparam int W   = 8;
    localparam int M   = 4;
    localparam int L   = 4;
    localparam int CW  = 8;
    localparam int N   = M * L;
    localparam int AW  = 4;
    localparam int ACC = 20;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_ena;
    logic            i_vld;
    logic [M*W-1:0]  i_data;
    logic            i_coeff_wr;
    logic [AW-1:0]   i_coeff_addr;
    logic [CW-1:0]   i_coeff_data;
    logic            i_ovf_clr;
    logic [ACC-1:0]  o_data;
    logic            o_vld;
    logic            o_busy;
    logic            o_ovf;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: sample history per channel (index 0 newest) and coefficient table
    int hist [M][L];
    int cm   [N];
    int frame[M];

    always #5 i_clk = ~i_clk;

    ppd_subfilter_bank #(
        .gp_idata_width(W), .gp_decimation_factor(M),
        .gp_taps_per_phase(L), .gp_coeff_width(CW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena), .i_vld(i_vld), .i_data(i_data),
        .i_coeff_wr(i_coeff_wr), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
        .i_ovf_clr(i_ovf_clr), .o_data(o_data), .o_vld(o_vld), .o_busy(o_busy), .o_ovf(o_ovf)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [ACC-1:0] obs, input logic [ACC-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ACC-1:0] model_out();
        logic signed [63:0] s;
        s = 64'sd0;
        for (int b = 0; b < M; b++)
            for (int k = 0; k < L; k++)
                s += 64'(cm[b*L+k]) * 64'(hist[b][k]);
        return s[ACC-1:0];
    endfunction

    task automatic model_clear();
        for (int b = 0; b < M; b++)
            for (int k = 0; k < L; k++) hist[b][k] = 0;
        for (int a = 0; a < N; a++) cm[a] = 0;
    endtask

    task automatic model_push();
        for (int b = 0; b < M; b++) begin
            for (int k = L - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = frame[b];
        end
    endtask

    task automatic drive_frame();
        for (int b = 0; b < M; b++) i_data[b*W +: W] = frame[b][W-1:0];
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        model_clear();
    endtask

    task automatic write_coeff(input int a, input int v, input bit accepted);
        i_coeff_wr   = 1'b1;
        i_coeff_addr = AW'(a);
        i_coeff_data = v[CW-1:0];
        tick();
        i_coeff_wr = 1'b0;
        if (accepted) cm[a] = v;
    endtask

    // Accepted frame from IDLE; returns with the bench in cycle 1 of the computation
    task automatic start_frame();
        drive_frame();
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        model_push();
    endtask

    task automatic wait_result(input string tag, input int start_cycle, input int exp_lat);
        int cyc;
        cyc = start_cycle;
        while (o_vld !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, ACC'(cyc), ACC'(exp_lat));
        check({tag, "_data"}, o_data, model_out());
        check({tag, "_busy_done"}, ACC'(o_busy), 20'd1);
        tick();
        check({tag, "_vld_pulse"}, ACC'(o_vld), 20'd0);
        check({tag, "_idle"}, ACC'(o_busy), 20'd0);
    endtask

    task automatic watch_no_vld(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (o_vld === 1'b1) pulses++;
        end
        check(tag, ACC'(pulses), 20'd0);
    endtask

    task automatic rand_frame();
        for (int b = 0; b < M; b++) frame[b] = int'($urandom_range(255)) - 128;
    endtask

    task automatic load_rand_coeffs();
        for (int a = 0; a < N; a++) write_coeff(a, int'($urandom_range(255)) - 128, 1'b1);
    endtask

    initial begin
        i_rst = 1'b1; i_ena = 1'b1; i_vld = 1'b0; i_data = '0;
        i_coeff_wr = 1'b0; i_coeff_addr = '0; i_coeff_data = '0; i_ovf_clr = 1'b0;
        model_clear();
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state
        check("rst_data", o_data, 20'd0);
        check("rst_vld", ACC'(o_vld), 20'd0);
        check("rst_busy", ACC'(o_busy), 20'd0);
        check("rst_ovf", ACC'(o_ovf), 20'd0);

        // Impulse through channel 0 walks the branch-0 coefficients 1,2,3,4
        for (int a = 0; a < N; a++) write_coeff(a, a + 1, 1'b1);
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < M; b++) frame[b] = 0;
            if (f == 0) frame[0] = 1;
            start_frame();
            check("imp_busy", ACC'(o_busy), 20'd1);
            wait_result("imp", 1, 17);
            check("imp_value", o_data, ACC'(f + 1));
        end

        // Most negative operands everywhere: full-scale positive sum without wrap
        do_reset();
        for (int a = 0; a < N; a++) write_coeff(a, -128, 1'b1);
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < M; b++) frame[b] = -128;
            start_frame();
            wait_result("neg", 1, 17);
        end
        check("neg_full", o_data, 20'h40000);

        // Frame during MAC is dropped; drop outranks a simultaneous clear
        do_reset();
        load_rand_coeffs();
        rand_frame();
        start_frame();
        for (int i = 0; i < 4; i++) tick();
        rand_frame();
        drive_frame();
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        check("drop_ovf", ACC'(o_ovf), 20'd1);
        tick();
        tick();
        i_vld = 1'b1;
        i_ovf_clr = 1'b1;
        tick();
        i_vld = 1'b0;
        i_ovf_clr = 1'b0;
        check("drop_ovf_set_wins", ACC'(o_ovf), 20'd1);
        wait_result("drop", 9, 17);
        watch_no_vld("drop_single_vld", 20);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        check("ovf_clr", ACC'(o_ovf), 20'd0);

        // Enable stall mid-MAC; strobes during the stall must have no effect
        rand_frame();
        start_frame();
        for (int i = 0; i < 4; i++) tick();
        i_ena = 1'b0;
        i_vld = 1'b1;
        i_coeff_wr = 1'b1;
        i_coeff_addr = AW'(0);
        i_coeff_data = 8'h55;
        for (int i = 0; i < 3; i++) tick();
        i_ena = 1'b1;
        i_vld = 1'b0;
        i_coeff_wr = 1'b0;
        check("stall_ovf", ACC'(o_ovf), 20'd0);
        check("stall_busy", ACC'(o_busy), 20'd1);
        wait_result("stall", 8, 20);

        // Reset during MAC aborts the computation and clears history and coefficients
        rand_frame();
        start_frame();
        for (int i = 0; i < 7; i++) tick();
        i_rst = 1'b1;
        #1;
        check("abort_data", o_data, 20'd0);
        check("abort_busy", ACC'(o_busy), 20'd0);
        tick();
        i_rst = 1'b0;
        model_clear();
        watch_no_vld("abort_no_vld", 20);
        load_rand_coeffs();
        rand_frame();
        start_frame();
        wait_result("post_rst", 1, 17);

        // Coefficient write while busy is ignored
        rand_frame();
        start_frame();
        tick();
        tick();
        write_coeff(5, int'($urandom_range(255)) - 128, 1'b0);
        wait_result("wr_busy", 4, 17);

        // Coefficient write together with i_vld takes effect in that frame
        rand_frame();
        drive_frame();
        i_coeff_wr = 1'b1;
        i_coeff_addr = AW'(0);
        i_coeff_data = 8'h81;
        i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        i_coeff_wr = 1'b0;
        cm[0] = -127;
        model_push();
        wait_result("wr_with_vld", 1, 17);

        // Randomized frames and coefficients
        for (int r = 0; r < 3; r++) begin
            load_rand_coeffs();
            for (int f = 0; f < 3; f++) begin
                rand_frame();
                start_frame();
                wait_result("rand", 1, 17);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
